// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the M-extension path: decoder-facing op encoding and the
// MDU control-state encoding.
package ysyx_24080006_pkg;

  typedef enum logic [1:0] {
    MULL = 2'd0,
    MULH = 2'd1,
    DIV  = 2'd2,
    REM  = 2'd3
  } mdu_op_t;

  typedef struct packed {
    mdu_op_t mdu_op;
    logic    signed_a;
    logic    signed_b;
  } mdu_set_t;

  // State literals carry a prefix because DIV already names an op.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_t;

  function automatic logic [31:0] absVal(input logic [31:0] v, input logic isSigned);
    return (isSigned && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_div.sv
// Restoring unsigned divider, MSB first, one quotient bit per cycle.
// The dividend register doubles as the quotient shift register.
module ysyx_24080006_mdu_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0]  dqReg;
  logic [XLEN-1:0]  dvsReg;
  logic [XLEN-1:0]  remReg;
  logic [CNT_W-1:0] cntReg;
  logic             busyReg;

  logic [XLEN:0]    remShift;
  logic [XLEN-1:0]  remDiff;
  logic             ge;

  // remShift needs one extra bit: a remainder just under a large divisor can
  // overflow XLEN bits after the shift.
  always_comb begin
    remShift = {remReg, dqReg[XLEN-1]};
    ge       = (remShift >= {1'b0, dvsReg});
    remDiff  = remShift[XLEN-1:0] - dvsReg;
  end

  assign busy      = busyReg;
  assign done      = busyReg && (cntReg == CNT_W'(XLEN - 1));
  assign quotient  = dqReg;
  assign remainder = remReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      dqReg   <= '0;
      dvsReg  <= '0;
      remReg  <= '0;
      cntReg  <= '0;
      busyReg <= 1'b0;
    end else if (flush) begin
      cntReg  <= '0;
      busyReg <= 1'b0;
    end else if (start) begin
      dqReg   <= dividend;
      dvsReg  <= divisor;
      remReg  <= '0;
      cntReg  <= '0;
      busyReg <= 1'b1;
    end else if (busyReg) begin
      remReg <= ge ? remDiff : remShift[XLEN-1:0];
      dqReg  <= {dqReg[XLEN-2:0], ge};
      cntReg <= cntReg + CNT_W'(1);
      if (done) busyReg <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_24080006_mdu.sv
// RV32M multiply/divide unit: shift-add multiplier inline, restoring divider
// in a sub-module, sign fix-up in one extra cycle, valid/ready result port.
module ysyx_24080006_mdu
  import ysyx_24080006_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_op_t         mdu_op,
  input  logic            signed_a,
  input  logic            signed_b,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  mdu_state_t        stateReg;
  mdu_op_t           opReg;
  logic              negQReg;
  logic              negRReg;
  logic [XLEN-1:0]   mcandReg;
  logic [XLEN-1:0]   mplierReg;
  logic [2*XLEN-1:0] prodReg;
  logic [CNT_W-1:0]  cntReg;
  logic              outValidReg;
  logic [XLEN-1:0]   resultReg;

  logic [XLEN-1:0]   magA;
  logic [XLEN-1:0]   magB;
  logic              signA;
  logic              signB;
  logic              accept;
  logic              isDivOp;
  logic              divByZero;
  logic              overflow;
  logic              special;
  logic [XLEN-1:0]   specialResult;
  logic              divStart;
  logic              divBusy;
  logic              divDone;
  logic [XLEN-1:0]   divQuo;
  logic [XLEN-1:0]   divRem;
  logic [2*XLEN-1:0] mulAddend;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quoFix;
  logic [XLEN-1:0]   remFix;
  logic [XLEN-1:0]   fixResult;

  assign in_ready  = (stateReg == ST_IDLE) && !reset;
  assign out_valid = outValidReg;
  assign result    = resultReg;

  always_comb begin
    magA      = absVal(a, signed_a);
    magB      = absVal(b, signed_b);
    signA     = signed_a && a[XLEN-1];
    signB     = signed_b && b[XLEN-1];
    accept    = in_valid && in_ready && !flush;
    isDivOp   = (mdu_op == DIV) || (mdu_op == REM);
    divByZero = (b == '0);
    overflow  = signed_a && signed_b && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special   = isDivOp && (divByZero || overflow);
    divStart  = accept && isDivOp && !special;
    if (divByZero) specialResult = (mdu_op == DIV) ? '1 : a;
    else           specialResult = (mdu_op == DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
  end

  // Sign restoration happens once on the finished magnitudes.
  always_comb begin
    mulAddend = {{XLEN{1'b0}}, mcandReg} << cntReg;
    prodFix   = negQReg ? -prodReg : prodReg;
    quoFix    = negQReg ? -divQuo : divQuo;
    remFix    = negRReg ? -divRem : divRem;
    case (opReg)
      MULL:    fixResult = prodFix[XLEN-1:0];
      MULH:    fixResult = prodFix[2*XLEN-1:XLEN];
      DIV:     fixResult = quoFix;
      default: fixResult = remFix;
    endcase
  end

  ysyx_24080006_mdu_div #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .start     (divStart),
    .dividend  (magA),
    .divisor   (magB),
    .busy      (divBusy),
    .done      (divDone),
    .quotient  (divQuo),
    .remainder (divRem)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg    <= ST_IDLE;
      opReg       <= MULL;
      negQReg     <= 1'b0;
      negRReg     <= 1'b0;
      mcandReg    <= '0;
      mplierReg   <= '0;
      prodReg     <= '0;
      cntReg      <= '0;
      outValidReg <= 1'b0;
      resultReg   <= '0;
    end else begin
      case (stateReg)
        ST_IDLE: begin
          if (accept) begin
            opReg     <= mdu_op;
            negQReg   <= signA ^ signB;
            negRReg   <= signA;
            mcandReg  <= magA;
            mplierReg <= magB;
            prodReg   <= '0;
            cntReg    <= '0;
            if (special) begin
              resultReg   <= specialResult;
              outValidReg <= 1'b1;
              stateReg    <= ST_DONE;
            end else begin
              stateReg <= isDivOp ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL: begin
          if (flush) begin
            stateReg <= ST_IDLE;
          end else begin
            if (mplierReg[0]) prodReg <= prodReg + mulAddend;
            mplierReg <= mplierReg >> 1;
            cntReg    <= cntReg + CNT_W'(1);
            if (cntReg == CNT_W'(XLEN - 1)) stateReg <= ST_FIX;
          end
        end
        ST_DIV: begin
          if (flush)                   stateReg <= ST_IDLE;
          else if (divBusy && divDone) stateReg <= ST_FIX;
        end
        ST_FIX: begin
          if (flush) begin
            stateReg <= ST_IDLE;
          end else begin
            resultReg   <= fixResult;
            outValidReg <= 1'b1;
            stateReg    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush || out_ready) begin
            outValidReg <= 1'b0;
            stateReg    <= ST_IDLE;
          end
        end
        default: begin
          outValidReg <= 1'b0;
          stateReg    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
